fft_frame_sink: RTL and testbench

FFT_FRAME_SINK -- requirements
Module: fft_frame_sink

---
 rtl/fft_sink_pkg.sv | 26 ++
 rtl/fft_sink_if.sv | 10 +
 rtl/fft_sink_ram.sv | 37 +++
 rtl/fft_frame_sink.sv | 156 +++++++++++++++
 tb/tb_fft_frame_sink.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_sink_pkg.sv
// Shared types and constants for the FFT frame sink: state encoding, tdata
// field layout and the signed-square helper used by the magnitude pipeline.
package fft_sink_pkg;

    typedef enum logic [1:0] {
        ST_RECV  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FULL  = 2'd2
    } sink_state_e;

    localparam int DEFAULT_FRAME_LEN = 128;
    localparam int REAL_LSB          = 0;
    localparam int IMAG_LSB          = 16;
    localparam int COMP_W            = 16;

    // Square of a signed 16-bit component; the worst case (-32768)^2 = 2^30
    // stays positive inside 32 bits.
    function automatic logic [31:0] square_s16(input logic signed [15:0] x);
        logic signed [31:0] xe;
        logic signed [31:0] p;
        xe = 32'(x);
        p  = xe * xe;
        return $unsigned(p);
    endfunction

endpackage

// File: rtl/fft_sink_if.sv
// Stream handshake bundle carrying FFT output beats ({imag, real}) into the sink.
interface fft_sink_if;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic [31:0] tdata;

    modport master (output tvalid, output tlast, output tdata, input tready);
    modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/fft_sink_ram.sv
// Simple dual-port frame buffer: one write port, one registered read-first read port.
module fft_sink_ram #(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [DEPTH];
    logic [31:0] rdata_r;

    // Storage array write port (contents deliberately not reset).
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read; a same-cycle write to raddr is not yet visible, so old data returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r <= 32'd0;
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/fft_frame_sink.sv
// Captures one FFT frame, stores |X|^2 per bin, tracks the peak bin and holds
// the frame until acknowledged.
module fft_frame_sink
    import fft_sink_pkg::*;
#(
    parameter int FRAME_LEN = DEFAULT_FRAME_LEN,
    parameter int AW        = $clog2(FRAME_LEN)
) (
    input  logic          aclk,
    input  logic          areset,
    fft_sink_if.slave     s_axis_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    output logic          frame_done,
    output logic          buf_full,
    input  logic          frame_ack,
    output logic [31:0]   peak_mag,
    output logic [AW-1:0] peak_idx,
    output logic [AW:0]   frame_len_out,
    output logic          event_tlast_unexpected,
    output logic          event_tlast_missing
);

    localparam logic [AW-1:0] LAST_BIN = AW'(FRAME_LEN - 1);

    sink_state_e   state_r;
    sink_state_e   state_s;
    logic [AW-1:0] wr_cnt_r;
    logic          tready_r;
    logic          buf_full_r;
    logic          frame_done_r;
    logic          ev_unexp_r;
    logic          ev_miss_r;
    logic [AW:0]   frame_len_r;
    logic [31:0]   peak_mag_r;
    logic [AW-1:0] peak_idx_r;

    logic          s1_valid_r;
    logic [AW-1:0] s1_addr_r;
    logic [31:0]   re2_r;
    logic [31:0]   im2_r;
    logic [31:0]   sum_s;

    logic          hs_s;
    logic          at_last_bin_s;
    logic          close_s;

    assign hs_s          = s_axis_data.tvalid && tready_r;
    assign at_last_bin_s = (wr_cnt_r == LAST_BIN);
    assign close_s       = hs_s && (s_axis_data.tlast || at_last_bin_s);
    assign sum_s         = re2_r + im2_r;

    // Next-state logic for the receive / drain / hold sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_RECV: begin
                if (close_s) state_s = ST_DRAIN;
                else         state_s = ST_RECV;
            end
            // The closing beat sits in stage 1 and its write lands on this edge.
            ST_DRAIN: state_s = ST_FULL;
            ST_FULL: begin
                if (frame_ack) state_s = ST_RECV;
                else           state_s = ST_FULL;
            end
            default: state_s = ST_RECV;
        endcase
    end

    // Control registers: state, bin counter, status and event pulses.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r      <= ST_RECV;
            wr_cnt_r     <= '0;
            tready_r     <= 1'b1;
            buf_full_r   <= 1'b0;
            frame_done_r <= 1'b0;
            ev_unexp_r   <= 1'b0;
            ev_miss_r    <= 1'b0;
            frame_len_r  <= '0;
        end else begin
            state_r      <= state_s;
            tready_r     <= (state_s == ST_RECV);
            buf_full_r   <= (state_s == ST_FULL);
            frame_done_r <= (state_r == ST_DRAIN) && (state_s == ST_FULL);
            ev_unexp_r   <= hs_s && s_axis_data.tlast && !at_last_bin_s;
            ev_miss_r    <= hs_s && !s_axis_data.tlast && at_last_bin_s;
            if ((state_r == ST_FULL) && frame_ack) begin
                wr_cnt_r <= '0;
            end else if (hs_s) begin
                wr_cnt_r <= wr_cnt_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (close_s) begin
                frame_len_r <= {1'b0, wr_cnt_r} + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Magnitude stage 1: component squares and target bin.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            s1_valid_r <= 1'b0;
            s1_addr_r  <= '0;
            re2_r      <= 32'd0;
            im2_r      <= 32'd0;
        end else begin
            s1_valid_r <= hs_s;
            if (hs_s) begin
                s1_addr_r <= wr_cnt_r;
                re2_r     <= square_s16(s_axis_data.tdata[REAL_LSB +: COMP_W]);
                im2_r     <= square_s16(s_axis_data.tdata[IMAG_LSB +: COMP_W]);
            end
        end
    end

    // Peak tracker: cleared by a frame's first beat, strict compare keeps the lowest bin on ties.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            peak_mag_r <= 32'd0;
            peak_idx_r <= '0;
        end else if (hs_s && (wr_cnt_r == '0)) begin
            peak_mag_r <= 32'd0;
            peak_idx_r <= '0;
        end else if (s1_valid_r && (sum_s > peak_mag_r)) begin
            peak_mag_r <= sum_s;
            peak_idx_r <= s1_addr_r;
        end
    end

    // Stage 2: the summed magnitude is written into the frame buffer.
    fft_sink_ram #(
        .DEPTH (FRAME_LEN),
        .AW    (AW)
    ) u_ram (
        .clk   (aclk),
        .rst   (areset),
        .we    (s1_valid_r),
        .waddr (s1_addr_r),
        .wdata (sum_s),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign s_axis_data.tready     = tready_r;
    assign buf_full               = buf_full_r;
    assign frame_done             = frame_done_r;
    assign event_tlast_unexpected = ev_unexp_r;
    assign event_tlast_missing    = ev_miss_r;
    assign frame_len_out          = frame_len_r;
    assign peak_mag               = peak_mag_r;
    assign peak_idx               = peak_idx_r;

endmodule

// File: tb/tb_fft_frame_sink.sv
// Directed bench for fft_frame_sink: table-driven bin contents plus hand-built
// sequences for early/missing tlast, stall-until-ack and mid-frame reset.
module tb_fft_frame_sink;
    import fft_sink_pkg::*;

    localparam int FL  = 128;
    localparam int AWB = 7;

    logic            aclk = 1'b0;
    logic            areset;
    logic            rd_en;
    logic [AWB-1:0]  rd_addr;
    logic [31:0]     rd_data;
    logic            frame_done;
    logic            buf_full;
    logic            frame_ack;
    logic [31:0]     peak_mag;
    logic [AWB-1:0]  peak_idx;
    logic [AWB:0]    frame_len_out;
    logic            ev_unexp;
    logic            ev_miss;

    fft_sink_if s_axis_data();

    fft_frame_sink #(.FRAME_LEN(FL), .AW(AWB)) dut (
        .aclk                   (aclk),
        .areset                 (areset),
        .s_axis_data            (s_axis_data),
        .rd_en                  (rd_en),
        .rd_addr                (rd_addr),
        .rd_data                (rd_data),
        .frame_done             (frame_done),
        .buf_full               (buf_full),
        .frame_ack              (frame_ack),
        .peak_mag               (peak_mag),
        .peak_idx               (peak_idx),
        .frame_len_out          (frame_len_out),
        .event_tlast_unexpected (ev_unexp),
        .event_tlast_missing    (ev_miss)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int          bin;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t        vt [5];
    logic [31:0] frame_data [FL];
    logic [31:0] rv;
    int          checks = 0;
    int          errors = 0;
    int          beats  = 0;
    int          fd_cnt = 0, unexp_cnt = 0, miss_cnt = 0;
    int          unexp_at = -1, miss_at = -1;
    int          fd0, un0, mi0;

    // Pulse monitor sampled away from the active edge.
    always @(negedge aclk) begin
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (ev_unexp) begin
            unexp_cnt <= unexp_cnt + 1;
            unexp_at  <= beats;
        end
        if (ev_miss) begin
            miss_cnt <= miss_cnt + 1;
            miss_at  <= beats;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last, input logic ack);
        int guard = 0;
        @(negedge aclk);
        s_axis_data.tvalid = 1'b1;
        s_axis_data.tdata  = d;
        s_axis_data.tlast  = last;
        frame_ack          = ack;
        while (!s_axis_data.tready && guard < 50) begin
            @(negedge aclk);
            guard++;
        end
        if (!s_axis_data.tready) check("beat_accept_timeout", 32'd0, 32'd1);
        else begin
            @(posedge aclk);
            beats++;
        end
    endtask

    task automatic send_frame(input int first, input int n, input bit last_at_end);
        for (int i = 0; i < n; i++)
            send_beat(frame_data[first + i], last_at_end && (i == n - 1), 1'b0);
    endtask

    task automatic go_idle();
        @(negedge aclk);
        s_axis_data.tvalid = 1'b0;
        s_axis_data.tlast  = 1'b0;
        frame_ack          = 1'b0;
    endtask

    task automatic wait_full();
        int g = 0;
        while (!buf_full && g < 20) begin
            @(negedge aclk);
            g++;
        end
        check("buf_full_rise", buf_full, 32'd1);
        @(negedge aclk);
    endtask

    task automatic ack_frame();
        @(negedge aclk);
        frame_ack = 1'b1;
        @(negedge aclk);
        frame_ack = 1'b0;
        check("ack_buf_full", buf_full, 32'd0);
        check("ack_tready", s_axis_data.tready, 32'd1);
    endtask

    task automatic read_bin(input int a, output logic [31:0] d);
        @(negedge aclk);
        rd_en   = 1'b1;
        rd_addr = AWB'(a);
        @(negedge aclk);
        rd_en = 1'b0;
        d     = rd_data;
    endtask

    task automatic clear_frame();
        for (int i = 0; i < FL; i++) frame_data[i] = 32'd0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{2,   32'h0004_0003, 32'd25};
        vt[1] = '{5,   32'h8000_8000, 32'h8000_0000};
        vt[2] = '{7,   32'h0000_FFFF, 32'd1};
        vt[3] = '{10,  32'h8000_7FFF, 32'h7FFF_0001};
        vt[4] = '{127, 32'h0190_FED4, 32'd250000};

        areset = 1'b1;
        s_axis_data.tvalid = 1'b0;
        s_axis_data.tlast  = 1'b0;
        s_axis_data.tdata  = 32'd0;
        rd_en = 1'b0;
        rd_addr = '0;
        frame_ack = 1'b0;
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);

        // Reset state.
        check("rst_tready", s_axis_data.tready, 32'd1);
        check("rst_buf_full", buf_full, 32'd0);
        check("rst_frame_done", frame_done, 32'd0);
        check("rst_peak_mag", peak_mag, 32'd0);
        check("rst_peak_idx", peak_idx, 32'd0);
        check("rst_frame_len", frame_len_out, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_events", {ev_unexp, ev_miss}, 32'd0);

        // Full frame, bin 0 = {0,100}, tlast on beat 127.
        clear_frame();
        frame_data[0] = 32'h0000_0064;
        fd0 = fd_cnt; un0 = unexp_cnt; mi0 = miss_cnt;
        send_frame(0, FL, 1'b1);
        @(negedge aclk);
        check("close_tready_low", s_axis_data.tready, 32'd0);
        wait_full();
        check("f1_frame_done", fd_cnt - fd0, 32'd1);
        check("f1_events", (unexp_cnt - un0) + (miss_cnt - mi0), 32'd0);
        check("f1_peak_mag", peak_mag, 32'd10000);
        check("f1_peak_idx", peak_idx, 32'd0);
        check("f1_frame_len", frame_len_out, 32'd128);
        for (int i = 0; i < FL; i++) begin
            read_bin(i, rv);
            check($sformatf("f1_bin%0d", i), rv, (i == 0) ? 32'd10000 : 32'd0);
        end
        @(negedge aclk);
        check("rd_hold", rd_data, 32'd0);
        go_idle();
        ack_frame();

        // Table-driven frame contents including the -32768 corner.
        clear_frame();
        for (int j = 0; j < 5; j++) frame_data[vt[j].bin] = vt[j].data;
        send_frame(0, FL, 1'b1);
        go_idle();
        wait_full();
        for (int j = 0; j < 5; j++) begin
            read_bin(vt[j].bin, rv);
            check($sformatf("tbl_bin%0d", vt[j].bin), rv, vt[j].exp);
        end
        read_bin(0, rv);
        check("tbl_bin0_overwritten", rv, 32'd0);
        check("tbl_peak_mag", peak_mag, 32'h8000_0000);
        check("tbl_peak_idx", peak_idx, 32'd5);
        ack_frame();

        // Tie on bins 3 and 9, plus read/write collision on bin 2 (old value 25).
        clear_frame();
        frame_data[3] = 32'h0000_0032;
        frame_data[9] = 32'h0000_0032;
        send_frame(0, 3, 1'b0);
        @(negedge aclk);
        s_axis_data.tvalid = 1'b0;
        rd_en   = 1'b1;
        rd_addr = AWB'(2);
        @(negedge aclk);
        rd_en = 1'b0;
        check("collide_old_data", rd_data, 32'd25);
        send_frame(3, FL - 3, 1'b1);
        go_idle();
        wait_full();
        read_bin(2, rv);
        check("collide_new_data", rv, 32'd0);
        check("tie_peak_mag", peak_mag, 32'd2500);
        check("tie_peak_idx", peak_idx, 32'd3);
        ack_frame();

        // Early tlast on beat 63; frame_ack during RECV must be ignored.
        clear_frame();
        frame_data[20] = 32'h0000_0009;
        fd0 = fd_cnt; un0 = unexp_cnt; mi0 = miss_cnt;
        beats = 0;
        for (int i = 0; i < 64; i++) send_beat(frame_data[i], i == 63, i < 63);
        wait_full();
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            check("early_stall_tready", s_axis_data.tready, 32'd0);
        end
        check("early_unexp_cnt", unexp_cnt - un0, 32'd1);
        check("early_unexp_at", unexp_at, 32'd64);
        check("early_miss_cnt", miss_cnt - mi0, 32'd0);
        check("early_frame_done", fd_cnt - fd0, 32'd1);
        check("early_frame_len", frame_len_out, 32'd64);
        check("early_peak", peak_mag, 32'd81);
        go_idle();
        ack_frame();

        // No tlast: event on beat 127, beat 128 stalls until ack then lands at bin 0.
        clear_frame();
        fd0 = fd_cnt; un0 = unexp_cnt; mi0 = miss_cnt;
        beats = 0;
        send_frame(0, FL, 1'b0);
        wait_full();
        check("miss_cnt", miss_cnt - mi0, 32'd1);
        check("miss_at", miss_at, 32'd128);
        check("miss_unexp_cnt", unexp_cnt - un0, 32'd0);
        check("miss_frame_done", fd_cnt - fd0, 32'd1);
        check("miss_frame_len", frame_len_out, 32'd128);
        @(negedge aclk);
        s_axis_data.tvalid = 1'b1;
        s_axis_data.tdata  = 32'h0000_0007;
        s_axis_data.tlast  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            check("miss_stall_tready", s_axis_data.tready, 32'd0);
        end
        check("miss_stall_beats", beats, 32'd128);
        frame_ack = 1'b1;
        @(negedge aclk);
        frame_ack = 1'b0;
        s_axis_data.tvalid = 1'b0;
        send_beat(32'h0000_0007, 1'b0, 1'b0);
        send_frame(1, FL - 1, 1'b1);
        go_idle();
        wait_full();
        read_bin(0, rv);
        check("stalled_beat_bin0", rv, 32'd49);
        check("stalled_peak_mag", peak_mag, 32'd49);
        check("stalled_peak_idx", peak_idx, 32'd0);
        ack_frame();

        // Reset after beat 40 discards the partial frame.
        read_bin(0, rv);
        clear_frame();
        frame_data[0] = 32'h0000_0064;
        send_frame(0, 41, 1'b0);
        @(negedge aclk);
        s_axis_data.tvalid = 1'b0;
        areset = 1'b1;
        fd0 = fd_cnt;
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        check("mid_rst_tready", s_axis_data.tready, 32'd1);
        check("mid_rst_buf_full", buf_full, 32'd0);
        check("mid_rst_peak_mag", peak_mag, 32'd0);
        check("mid_rst_peak_idx", peak_idx, 32'd0);
        check("mid_rst_frame_len", frame_len_out, 32'd0);
        check("mid_rst_rd_data", rd_data, 32'd0);
        check("mid_rst_events", {ev_unexp, ev_miss}, 32'd0);
        repeat (4) @(negedge aclk);
        check("mid_rst_no_done", fd_cnt - fd0, 32'd0);

        fd0 = fd_cnt; un0 = unexp_cnt; mi0 = miss_cnt;
        send_frame(0, FL, 1'b1);
        go_idle();
        wait_full();
        check("post_rst_frame_done", fd_cnt - fd0, 32'd1);
        check("post_rst_events", (unexp_cnt - un0) + (miss_cnt - mi0), 32'd0);
        check("post_rst_frame_len", frame_len_out, 32'd128);
        check("post_rst_peak_mag", peak_mag, 32'd10000);
        read_bin(0, rv);
        check("post_rst_bin0", rv, 32'd10000);
        read_bin(40, rv);
        check("post_rst_bin40", rv, 32'd0);
        ack_frame();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
